// File: rtl/qsn_shift_sched.sv
// qsn_shift_sched: issues one cyclic-shift command per cycle for a layer.
// A per-column shift table is programmed while idle. A start pulse walks
// num_cols entries (saturated to DEPTH). Each issue registers the left/right
// shifter selects and the lane merge mask of a length-Z QSN. The column tag
// is then delayed by QSN_LAT so that it lines up with the shifted data.
// Ports: sys_clk/rst clock and sync reset; cfg_we/cfg_addr/cfg_shift table
// write, cfg_err sticky error; start/num_cols launch; out_ready issue
// enable; busy/done status; left_sel/right_sel/merge_sel/sel_valid/sel_col
// shifter command; out_valid/out_col delay-matched data tag.
module qsn_shift_sched #(
  parameter int Z       = 17,
  parameter int SEL_W   = 5,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int QSN_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_shift,
  output logic              cfg_err,
  input  logic              start,
  input  logic [ADDR_W:0]   num_cols,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  left_sel,
  output logic [SEL_W-1:0]  right_sel,
  output logic [Z-1:0]      merge_sel,
  output logic              sel_valid,
  output logic [ADDR_W-1:0] sel_col,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_col
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  shift_tbl [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_ptr;
  logic              issue;
  logic              wr_ok;
  logic              pipe_empty;
  logic              vld_p [QSN_LAT];
  logic [ADDR_W-1:0] col_p [QSN_LAT];
  logic [SEL_W-1:0]  cur_shift;

  function automatic logic [SEL_W-1:0] right_sel_of(input logic [SEL_W-1:0] s);
    if (s == '0) return '0;
    return SEL_W'(Z - int'(s));
  endfunction

  function automatic logic [Z-1:0] merge_of(input logic [SEL_W-1:0] s);
    logic [Z-1:0] m;
    for (int i = 0; i < Z; i++) m[i] = (i < Z - int'(s));
    return m;
  endfunction

  // Saturates the requested count to DEPTH and returns the last column index.
  function automatic logic [ADDR_W-1:0] last_col_of(input logic [ADDR_W:0] n);
    logic [ADDR_W:0] c;
    c = (int'(n) > DEPTH) ? (ADDR_W+1)'(DEPTH) : n;
    return ADDR_W'(c - (ADDR_W+1)'(1));
  endfunction

  assign cur_shift = shift_tbl[ptr];
  assign wr_ok     = cfg_we && (state == IDLE) && (int'(cfg_shift) < Z);

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (num_cols != '0)) state_nxt = RUN;
      RUN:     if (issue && (ptr == last_ptr)) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == RUN) && out_ready;
  end

  // The last tag may sit in the output stage; everything upstream must be idle.
  always_comb begin
    pipe_empty = !sel_valid;
    for (int k = 0; k < QSN_LAT - 1; k++) begin
      if (vld_p[k]) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) shift_tbl[k] <= '0;
    end else if (wr_ok) begin
      shift_tbl[cfg_addr] <= cfg_shift;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ptr      <= '0;
      last_ptr <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done <= ((state == IDLE) && start && (num_cols == '0)) ||
              ((state == DRAIN) && pipe_empty);
      if ((state == IDLE) && start) begin
        ptr      <= '0;
        last_ptr <= last_col_of(num_cols);
      end else if (issue) begin
        ptr <= ptr + ADDR_W'(1);
      end
      if (cfg_we && !wr_ok) cfg_err <= 1'b1;
    end
  end

  // Stage p0: registered shifter command; selects hold across stall bubbles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sel_valid <= 1'b0;
      sel_col   <= '0;
      left_sel  <= '0;
      right_sel <= '0;
      merge_sel <= '0;
    end else begin
      sel_valid <= issue;
      if (issue) begin
        sel_col   <= ptr;
        left_sel  <= cur_shift;
        right_sel <= right_sel_of(cur_shift);
        merge_sel <= merge_of(cur_shift);
      end
    end
  end

  // Stages p1..pQSN_LAT: tag delay matching the shifter datapath.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int k = 0; k < QSN_LAT; k++) begin
        vld_p[k] <= 1'b0;
        col_p[k] <= '0;
      end
    end else begin
      vld_p[0] <= sel_valid;
      col_p[0] <= sel_col;
      for (int k = 1; k < QSN_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        col_p[k] <= col_p[k-1];
      end
    end
  end

  assign out_valid = vld_p[QSN_LAT-1];
  assign out_col   = col_p[QSN_LAT-1];

endmodule

// File: tb/tb_qsn_shift_sched.sv
module tb_qsn_shift_sched;

  localparam int Z = 17, SEL_W = 5, DEPTH = 16, ADDR_W = 4, LAT = 1;

  logic              sys_clk, rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [SEL_W-1:0]  cfg_shift;
  logic              cfg_err;
  logic              start;
  logic [ADDR_W:0]   num_cols;
  logic              out_ready;
  logic              busy, done;
  logic [SEL_W-1:0]  left_sel, right_sel;
  logic [Z-1:0]      merge_sel;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_col;
  logic              out_valid;
  logic [ADDR_W-1:0] out_col;

  qsn_shift_sched #(.Z(Z), .SEL_W(SEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .QSN_LAT(LAT)) dut (
    .sys_clk(sys_clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift),
    .cfg_err(cfg_err), .start(start), .num_cols(num_cols), .out_ready(out_ready), .busy(busy),
    .done(done), .left_sel(left_sel), .right_sel(right_sel), .merge_sel(merge_sel),
    .sel_valid(sel_valid), .sel_col(sel_col), .out_valid(out_valid), .out_col(out_col)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [SEL_W-1:0] shift;
    logic [SEL_W-1:0] l;
    logic [SEL_W-1:0] r;
    logic [Z-1:0]     m;
  } vec_t;

  vec_t vt [4];
  vec_t zero_v;
  vec_t col_exp [16];
  int   exp_cyc [32];

  int nvec = 0, nfail = 0;

  int n_sel, n_out, done_cyc;
  logic busy_at_done;
  int sel_cyc [32], sel_colr [32], out_cyc [32], out_colr [32];
  logic [SEL_W-1:0] sel_l [32], sel_r [32];
  logic [Z-1:0]     sel_m [32];
  logic [63:0] sv_pat, ov_pat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int v);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_shift = SEL_W'(v);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " sel_valid"}, sel_valid, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " left_sel"}, left_sel, 0);
    chk({tag, " right_sel"}, right_sel, 0);
    chk({tag, " merge_sel"}, merge_sel, 0);
    chk({tag, " sel_col"}, sel_col, 0);
    chk({tag, " out_col"}, out_col, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " cfg_err"}, cfg_err, 0);
  endtask

  // Launch a layer and log every issue, output tag and the done pulse.
  // Cycle 0 is the first sample after the edge that captured start.
  task automatic run_seq(input int ncols, input logic [63:0] stall,
                         input int wr_c, input int wr_a, input int wr_v);
    n_sel = 0; n_out = 0; done_cyc = -1; busy_at_done = 1'b1;
    sv_pat = '0; ov_pat = '0;
    start = 1'b1; num_cols = (ADDR_W+1)'(ncols); out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      if (c < 64) begin
        sv_pat[c] = sel_valid;
        ov_pat[c] = out_valid;
      end
      if (sel_valid && n_sel < 32) begin
        sel_cyc[n_sel] = c; sel_colr[n_sel] = int'(sel_col);
        sel_l[n_sel] = left_sel; sel_r[n_sel] = right_sel; sel_m[n_sel] = merge_sel;
        n_sel++;
      end else if (!sel_valid && n_sel > 0 && n_sel <= 16) begin
        chk($sformatf("hold left c%0d", c), left_sel, col_exp[n_sel-1].l);
        chk($sformatf("hold right c%0d", c), right_sel, col_exp[n_sel-1].r);
        chk($sformatf("hold merge c%0d", c), merge_sel, col_exp[n_sel-1].m);
      end
      if (out_valid && n_out < 32) begin
        out_cyc[n_out] = c; out_colr[n_out] = int'(out_col);
        n_out++;
      end
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
      end
      out_ready = (c < 64) ? !stall[c] : 1'b1;
      cfg_we = (c == wr_c);
      cfg_addr = ADDR_W'(wr_a);
      cfg_shift = SEL_W'(wr_v);
      if (done_cyc < 0) step();
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    if (done_cyc < 0) chk("done timeout", 0, 1);
  endtask

  task automatic check_issues(input string tag, input int n);
    chk({tag, " issue count"}, n_sel, n);
    chk({tag, " out count"}, n_out, n);
    for (int k = 0; k < n && k < 32; k++) begin
      chk($sformatf("%s sel cycle %0d", tag, k), sel_cyc[k], exp_cyc[k]);
      chk($sformatf("%s sel_col %0d", tag, k), sel_colr[k], k);
      chk($sformatf("%s left_sel %0d", tag, k), sel_l[k], col_exp[k].l);
      chk($sformatf("%s right_sel %0d", tag, k), sel_r[k], col_exp[k].r);
      chk($sformatf("%s merge_sel %0d", tag, k), sel_m[k], col_exp[k].m);
      chk($sformatf("%s out cycle %0d", tag, k), out_cyc[k], exp_cyc[k] + LAT);
      chk($sformatf("%s out_col %0d", tag, k), out_colr[k], k);
    end
    chk({tag, " done cycle"}, done_cyc, exp_cyc[n-1] + LAT + 1);
    chk({tag, " busy at done"}, busy_at_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{shift: 5'd0,  l: 5'd0,  r: 5'd0,  m: 17'h1FFFF};
    vt[1] = '{shift: 5'd1,  l: 5'd1,  r: 5'd16, m: 17'h0FFFF};
    vt[2] = '{shift: 5'd16, l: 5'd16, r: 5'd1,  m: 17'h00001};
    vt[3] = '{shift: 5'd5,  l: 5'd5,  r: 5'd12, m: 17'h00FFF};
    zero_v = vt[0];

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0;
    start = 1'b0; num_cols = '0; out_ready = 1'b1;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Shift table and column order
    for (int k = 0; k < 4; k++) cfg_write(k, int'(vt[k].shift));
    for (int k = 0; k < 4; k++) col_exp[k] = vt[k];
    for (int k = 0; k < 32; k++) exp_cyc[k] = 1 + k;
    run_seq(4, 64'h0, -1, 0, 0);
    check_issues("basic", 4);
    chk("basic cfg_err", cfg_err, 0);
    step();

    // Three stall cycles after the first issue
    exp_cyc[0] = 1; exp_cyc[1] = 5; exp_cyc[2] = 6; exp_cyc[3] = 7;
    run_seq(4, 64'hE, -1, 0, 0);
    check_issues("stall", 4);
    chk("stall sel_valid pattern", sv_pat[15:0], 16'h00E2);
    chk("stall out_valid pattern", ov_pat[15:0], 16'((64'hE2) << LAT));
    step();

    // Zero columns
    run_seq(0, 64'h0, -1, 0, 0);
    chk("zero done cycle", done_cyc, 0);
    chk("zero busy at done", busy_at_done, 0);
    chk("zero issue count", n_sel, 0);
    step();
    chk("zero done cleared", done, 0);
    chk("zero busy idle", busy, 0);
    chk("zero no sel_valid", sel_valid, 0);

    // Illegal shift value leaves the table intact
    cfg_write(2, 17);
    chk("illegal cfg_err", cfg_err, 1);
    for (int k = 0; k < 32; k++) exp_cyc[k] = 1 + k;
    run_seq(4, 64'h0, -1, 0, 0);
    check_issues("illegal", 4);
    step();

    // Clamp to DEPTH and reject a write while busy
    rst = 1'b1;
    step();
    chk_all_zero("reset2");
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) cfg_write(k, int'(vt[k].shift));
    for (int k = 0; k < 16; k++) col_exp[k] = (k < 4) ? vt[k] : zero_v;
    run_seq(20, 64'h0, 3, 5, 3);
    check_issues("clamp", 16);
    chk("clamp busy-write cfg_err", cfg_err, 1);
    step();

    // Reset during the second issue cycle
    start = 1'b1; num_cols = 5'd4; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("midrst first issue seen", sel_valid, 1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("midrst no done %0d", k), done, 0);
      chk($sformatf("midrst idle %0d", k), busy, 0);
    end
    col_exp[0] = zero_v; col_exp[1] = zero_v;
    for (int k = 0; k < 32; k++) exp_cyc[k] = 1 + k;
    run_seq(2, 64'h0, -1, 0, 0);
    check_issues("after-rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
